accel_fifo_port: RTL and testbench

Accelerator-side endpoint of the router data-bus protocol, instantiated once per accelerator (FFT, FIR, IIR).
- To-accelerator FIFO: the router pushes with put_req; the accelerator core pops.
- From-accelerator FIFO: the core pushes; the router pops with get_req.
- Reports the four empty/full flags the router uses to choose its transfer direction.

---
 rtl/accel_fifo_port.sv | 193 +++++++++++++++++++
 tb/tb_accel_fifo_port.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_fifo_port.sv
// Accelerator-side endpoint of the router data bus: one to-accelerator
// FIFO (router pushes, core pops) and one from-accelerator FIFO (core
// pushes, router pops).  Each FIFO has registered flags and count, a
// registered 1-cycle-latency read port, and reports dropped pushes and
// missed pops so the top level can keep the sticky error bits.

module accel_fifo_port_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  push_drop_o,
    output logic                  pop_miss_o
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Decide which requests succeed (based on pre-update count) and compute next state.
    always_comb begin
        push_ok_s = push_i && (count_q != CNT_FULL);
        pop_ok_s  = pop_i && (count_q != CNT_ZERO);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            data_d   = mem_q[rd_ptr_q];
            valid_d  = 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
            data_d   = data_q;
            valid_d  = 1'b0;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == CNT_ZERO);
        full_d  = (count_d == CNT_FULL);
    end

    // State registers: pointers, count, flags and the read output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            data_q   <= {DATA_WIDTH{1'b0}};
            valid_q  <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage array; a push during reset is ignored so nothing is written.
    always_ff @(posedge clk) begin
        if (reset && push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o  = data_q;
    assign pop_valid_o = valid_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign count_o     = count_q;
    assign push_drop_o = push_i && (count_q == CNT_FULL);
    assign pop_miss_o  = pop_i && (count_q == CNT_ZERO);

endmodule

module accel_fifo_port #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  put_req,
    input  logic [DATA_WIDTH-1:0] router_data_in,
    input  logic                  get_req,
    output logic [DATA_WIDTH-1:0] router_data_out,
    output logic                  router_data_valid,
    input  logic                  acc_pop,
    output logic [DATA_WIDTH-1:0] acc_data_out,
    output logic                  acc_data_valid,
    input  logic                  acc_push,
    input  logic [DATA_WIDTH-1:0] acc_data_in,
    output logic                  to_empty,
    output logic                  to_full,
    output logic                  from_empty,
    output logic                  from_full,
    output logic [ADDR_WIDTH:0]   to_count,
    output logic [ADDR_WIDTH:0]   from_count,
    output logic                  overflow,
    output logic                  underflow
);

    logic to_drop_s, to_miss_s;
    logic from_drop_s, from_miss_s;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Router -> accelerator direction.
    accel_fifo_port_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_to_fifo (
        .clk(clk), .reset(reset),
        .push_i(put_req), .push_data_i(router_data_in),
        .pop_i(acc_pop), .pop_data_o(acc_data_out), .pop_valid_o(acc_data_valid),
        .empty_o(to_empty), .full_o(to_full), .count_o(to_count),
        .push_drop_o(to_drop_s), .pop_miss_o(to_miss_s)
    );

    // Accelerator -> router direction.
    accel_fifo_port_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_from_fifo (
        .clk(clk), .reset(reset),
        .push_i(acc_push), .push_data_i(acc_data_in),
        .pop_i(get_req), .pop_data_o(router_data_out), .pop_valid_o(router_data_valid),
        .empty_o(from_empty), .full_o(from_full), .count_o(from_count),
        .push_drop_o(from_drop_s), .pop_miss_o(from_miss_s)
    );

    // Accumulate error events from both FIFOs into the sticky bits.
    always_comb begin
        overflow_d  = overflow_q | to_drop_s | from_drop_s;
        underflow_d = underflow_q | to_miss_s | from_miss_s;
    end

    // Sticky error registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_accel_fifo_port.sv
// Directed self-checking bench for accel_fifo_port.  Inputs change 1ns after
// a rising edge; outputs are sampled 1ns after the following rising edge.

module tb_accel_fifo_port;

    logic         clk = 1'b0;
    logic         reset;
    logic         put_req, get_req, acc_pop, acc_push;
    logic [127:0] router_data_in, acc_data_in;
    logic [127:0] router_data_out, acc_data_out;
    logic         router_data_valid, acc_data_valid;
    logic         to_empty, to_full, from_empty, from_full;
    logic [3:0]   to_count, from_count;
    logic         overflow, underflow;

    int checks = 0;
    int errors = 0;

    accel_fifo_port #(.DATA_WIDTH(128), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset),
        .put_req(put_req), .router_data_in(router_data_in),
        .get_req(get_req), .router_data_out(router_data_out),
        .router_data_valid(router_data_valid),
        .acc_pop(acc_pop), .acc_data_out(acc_data_out),
        .acc_data_valid(acc_data_valid),
        .acc_push(acc_push), .acc_data_in(acc_data_in),
        .to_empty(to_empty), .to_full(to_full),
        .from_empty(from_empty), .from_full(from_full),
        .to_count(to_count), .from_count(from_count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({to_empty, from_empty, to_full, from_full} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1100", {to_empty, from_empty, to_full, from_full});
        end
        checks++;
        if ({to_count, from_count} !== 8'h00) begin
            errors++;
            $display("FAIL reset_counts: got %h expected 00", {to_count, from_count});
        end
        checks++;
        if ({router_data_valid, acc_data_valid, overflow, underflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valid_err: got %b expected 0000", {router_data_valid, acc_data_valid, overflow, underflow});
        end
        checks++;
        if ((router_data_out !== 128'h0) || (acc_data_out !== 128'h0)) begin
            errors++;
            $display("FAIL reset_data: got %h / %h expected 0", router_data_out, acc_data_out);
        end
    endtask

    task automatic test_to_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            put_req = 1'b1;
            router_data_in = 128'(i);
            tick();
        end
        put_req = 1'b0;
        checks++;
        if ({to_full, to_count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL to_full8: got full=%b count=%0d ovf=%b expected 1 8 0", to_full, to_count, overflow);
        end
        put_req = 1'b1;
        router_data_in = 128'h9;
        tick();
        put_req = 1'b0;
        checks++;
        if ({overflow, to_count} !== {1'b1, 4'd8}) begin
            errors++;
            $display("FAIL to_overflow: got ovf=%b count=%0d expected 1 8", overflow, to_count);
        end
        for (int i = 1; i <= 8; i++) begin
            acc_pop = 1'b1;
            tick();
            acc_pop = 1'b0;
            checks++;
            if ((acc_data_valid !== 1'b1) || (acc_data_out !== 128'(i))) begin
                errors++;
                $display("FAIL to_pop_data: got v=%b %h expected 1 %h", acc_data_valid, acc_data_out, 128'(i));
            end
            tick();
            checks++;
            if ((acc_data_valid !== 1'b0) || (acc_data_out !== 128'(i))) begin
                errors++;
                $display("FAIL to_pop_pulse: got v=%b %h expected 0 %h", acc_data_valid, acc_data_out, 128'(i));
            end
        end
        checks++;
        if ({to_empty, to_count, underflow} !== {1'b1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL to_drained: got empty=%b count=%0d unf=%b expected 1 0 0", to_empty, to_count, underflow);
        end
    endtask

    task automatic test_get_empty();
        get_req = 1'b1;
        tick();
        get_req = 1'b0;
        checks++;
        if ({router_data_valid, underflow, from_count} !== {1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL get_empty: got v=%b unf=%b count=%0d expected 0 1 0", router_data_valid, underflow, from_count);
        end
        checks++;
        if (router_data_out !== 128'h0) begin
            errors++;
            $display("FAIL get_empty_data: got %h expected 0", router_data_out);
        end
    endtask

    task automatic test_from_wrap();
        for (int i = 0; i < 5; i++) begin
            acc_push = 1'b1;
            acc_data_in = 128'h50 + 128'(i);
            tick();
        end
        acc_push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            get_req = 1'b1;
            tick();
            get_req = 1'b0;
            checks++;
            if ((router_data_valid !== 1'b1) || (router_data_out !== 128'h50 + 128'(i))) begin
                errors++;
                $display("FAIL wrap_pop5: got v=%b %h expected 1 %h", router_data_valid, router_data_out, 128'h50 + 128'(i));
            end
        end
        for (int i = 0; i < 6; i++) begin
            acc_push = 1'b1;
            acc_data_in = 128'hA0 + 128'(i);
            tick();
        end
        acc_push = 1'b0;
        checks++;
        if (from_count !== 4'd6) begin
            errors++;
            $display("FAIL wrap_count6: got %0d expected 6", from_count);
        end
        for (int i = 0; i < 6; i++) begin
            get_req = 1'b1;
            tick();
            get_req = 1'b0;
            checks++;
            if ((router_data_valid !== 1'b1) || (router_data_out !== 128'hA0 + 128'(i))) begin
                errors++;
                $display("FAIL wrap_pop6: got v=%b %h expected 1 %h", router_data_valid, router_data_out, 128'hA0 + 128'(i));
            end
        end
        checks++;
        if ({from_empty, from_count} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL wrap_empty: got empty=%b count=%0d expected 1 0", from_empty, from_count);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        // count 3: both proceed
        for (int i = 0; i < 3; i++) begin
            acc_push = 1'b1;
            acc_data_in = 128'hC0 + 128'(i);
            tick();
        end
        acc_data_in = 128'hC3;
        get_req = 1'b1;
        tick();
        acc_push = 1'b0;
        get_req = 1'b0;
        checks++;
        if ({from_count, router_data_valid} !== {4'd3, 1'b1} || router_data_out !== 128'hC0) begin
            errors++;
            $display("FAIL simul3: got count=%0d v=%b %h expected 3 1 c0", from_count, router_data_valid, router_data_out);
        end
        for (int i = 1; i <= 3; i++) begin
            get_req = 1'b1;
            tick();
            get_req = 1'b0;
            checks++;
            if (router_data_out !== 128'hC0 + 128'(i)) begin
                errors++;
                $display("FAIL simul3_drain: got %h expected %h", router_data_out, 128'hC0 + 128'(i));
            end
        end
        checks++;
        if ({from_count, underflow} !== {4'd0, 1'b0}) begin
            errors++;
            $display("FAIL simul3_end: got count=%0d unf=%b expected 0 0", from_count, underflow);
        end
        // count 0: push succeeds, pop underflows
        acc_push = 1'b1;
        acc_data_in = 128'hD0;
        get_req = 1'b1;
        tick();
        get_req = 1'b0;
        checks++;
        if ({from_count, underflow, router_data_valid} !== {4'd1, 1'b1, 1'b0} || router_data_out !== 128'hC3) begin
            errors++;
            $display("FAIL simul0: got count=%0d unf=%b v=%b %h expected 1 1 0 c3", from_count, underflow, router_data_valid, router_data_out);
        end
        for (int i = 1; i < 8; i++) begin
            acc_data_in = 128'hD0 + 128'(i);
            tick();
        end
        checks++;
        if ({from_full, from_count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
            errors++;
            $display("FAIL simul_fill: got full=%b count=%0d ovf=%b expected 1 8 0", from_full, from_count, overflow);
        end
        // count 8: pop succeeds, push overflows
        acc_data_in = 128'hE0;
        get_req = 1'b1;
        tick();
        acc_push = 1'b0;
        get_req = 1'b0;
        checks++;
        if ({from_count, overflow, router_data_valid} !== {4'd7, 1'b1, 1'b1} || router_data_out !== 128'hD0) begin
            errors++;
            $display("FAIL simul8: got count=%0d ovf=%b v=%b %h expected 7 1 1 d0", from_count, overflow, router_data_valid, router_data_out);
        end
        for (int i = 1; i < 8; i++) begin
            get_req = 1'b1;
            tick();
            get_req = 1'b0;
            checks++;
            if (router_data_out !== 128'hD0 + 128'(i)) begin
                errors++;
                $display("FAIL simul8_drain: got %h expected %h", router_data_out, 128'hD0 + 128'(i));
            end
        end
        checks++;
        if ({from_empty, from_count} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL simul8_end: got empty=%b count=%0d expected 1 0", from_empty, from_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            put_req = 1'b1;
            router_data_in = 128'h60 + 128'(i);
            tick();
        end
        checks++;
        if (to_count !== 4'd5) begin
            errors++;
            $display("FAIL mid_count5: got %0d expected 5", to_count);
        end
        router_data_in = 128'h77;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        put_req = 1'b0;
        checks++;
        if ({to_count, to_empty, overflow, underflow} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got count=%0d empty=%b ovf=%b unf=%b expected 0 1 0 0", to_count, to_empty, overflow, underflow);
        end
        acc_pop = 1'b1;
        tick();
        acc_pop = 1'b0;
        checks++;
        if ({acc_data_valid, underflow} !== 2'b01 || acc_data_out !== 128'h0) begin
            errors++;
            $display("FAIL mid_pop_empty: got v=%b unf=%b %h expected 0 1 0", acc_data_valid, underflow, acc_data_out);
        end
        put_req = 1'b1;
        router_data_in = 128'h99;
        tick();
        put_req = 1'b0;
        acc_pop = 1'b1;
        tick();
        acc_pop = 1'b0;
        checks++;
        if ((acc_data_valid !== 1'b1) || (acc_data_out !== 128'h99)) begin
            errors++;
            $display("FAIL mid_after: got v=%b %h expected 1 99", acc_data_valid, acc_data_out);
        end
    endtask

    initial begin
        reset = 1'b0;
        put_req = 1'b0;
        get_req = 1'b0;
        acc_pop = 1'b0;
        acc_push = 1'b0;
        router_data_in = 128'h0;
        acc_data_in = 128'h0;
        test_reset();
        test_to_fill_drain();
        test_get_empty();
        test_from_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
